// File: rtl/lcd_pkg.sv
// Shared constants and types for the two-row LCD character frame buffer.
package lcd_pkg;

  localparam logic [7:0] LCD_BLANK = 8'h20;
  localparam int         COLS_MAX  = 40;
  localparam int         COL_W     = 6;

  typedef enum logic {
    SCAN,
    REQ
  } scan_state_e;

endpackage

// File: rtl/lcd_char_mem.sv
// Character store with one dirty bit per cell; host writes and clear mark cells
// dirty, the scanner clears the dirty bit of the cell it has just latched.
module lcd_char_mem
  import lcd_pkg::*;
#(
  parameter int COLS  = 16,
  parameter int IDX_W = $clog2(2 * COLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             scan_clr,
  output logic [7:0]       rd_char,
  output logic             rd_dirty,
  output logic             any_dirty
);

  localparam int CELLS = 2 * COLS;

  logic [7:0]       mem_q [CELLS];
  logic [CELLS-1:0] dirty_q;
  logic [6:0]       wr_lin;
  logic             wr_valid;

  assign wr_lin   = (wr_row ? 7'(COLS) : 7'd0) + {1'b0, wr_col};
  assign wr_valid = wr_en && ({1'b0, wr_col} < 7'(COLS));

  // NOTE: this array is reset on purpose because the first screen after reset
  // must be a full blank replay; a reset like this rules out mapping it to RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) begin
        mem_q[i] <= LCD_BLANK;
      end
      dirty_q <= '1;
    end else begin
      // NOTE: non-blocking assignments keep every cell update based on the
      // pre-edge state, so the scanner's read and the host write never race.
      for (int i = 0; i < CELLS; i++) begin
        if (clr) begin
          mem_q[i]   <= LCD_BLANK;
          dirty_q[i] <= 1'b1;
        end else if (wr_valid && (wr_lin == 7'(i))) begin
          mem_q[i]   <= wr_char;
          dirty_q[i] <= 1'b1;
        end else if (scan_clr && (rd_idx == IDX_W'(i))) begin
          dirty_q[i] <= 1'b0;
        end
      end
    end
  end

  // A write landing on the cell being latched keeps it dirty, so it is resent.
  assign rd_char   = mem_q[rd_idx];
  assign rd_dirty  = dirty_q[rd_idx];
  assign any_dirty = |dirty_q;

endmodule

// File: rtl/lcd_screen_buffer.sv
// Round-robin scanner that replays dirty cells to the LCD driver one rq/ack
// transaction per character.
module lcd_screen_buffer
  import lcd_pkg::*;
#(
  parameter int COLS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic             clr,
  output logic             busy,
  output logic             lcd_rq,
  input  logic             lcd_ack,
  output logic             lcd_row,
  output logic [COL_W-1:0] lcd_column,
  output logic [7:0]       lcd_character
);

  localparam int CELLS = 2 * COLS;
  localparam int IDX_W = $clog2(CELLS);

  scan_state_e      state_q;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             rq_q;
  logic             row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [7:0]       char_q;
  logic             busy_q;
  logic [6:0]       ptr_ext;

  logic [7:0]       rd_char;
  logic             rd_dirty;
  logic             any_dirty;
  logic             scan_clr;

  lcd_char_mem #(
    .COLS  (COLS),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_char   (wr_char),
    .clr       (clr),
    .rd_idx    (ptr_q),
    .scan_clr  (scan_clr),
    .rd_char   (rd_char),
    .rd_dirty  (rd_dirty),
    .any_dirty (any_dirty)
  );

  assign scan_clr = (state_q == SCAN) && rd_dirty;

  // NOTE: every variable gets its default first so this block cannot infer a latch.
  always_comb begin
    ptr_d   = ptr_q + IDX_W'(1);
    ptr_ext = 7'(ptr_q);
    row_d   = 1'b0;
    col_d   = '0;
    if (ptr_q == IDX_W'(CELLS - 1)) begin
      ptr_d = '0;
    end
    if (ptr_ext >= 7'(COLS)) begin
      row_d = 1'b1;
      col_d = COL_W'(ptr_ext - 7'(COLS));
    end else begin
      col_d = COL_W'(ptr_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      rq_q    <= 1'b0;
      row_q   <= 1'b0;
      col_q   <= '0;
      char_q  <= LCD_BLANK;
      busy_q  <= 1'b1;
    end else begin
      busy_q <= any_dirty | (state_q == REQ);
      case (state_q)
        SCAN: begin
          ptr_q <= ptr_d;
          if (rd_dirty) begin
            row_q   <= row_d;
            col_q   <= col_d;
            char_q  <= rd_char;
            rq_q    <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Outputs hold until the driver acknowledges; ack while idle is ignored.
          if (lcd_ack) begin
            rq_q    <= 1'b0;
            state_q <= SCAN;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign busy          = busy_q;
  assign lcd_rq        = rq_q;
  assign lcd_row       = row_q;
  assign lcd_column    = col_q;
  assign lcd_character = char_q;

endmodule

// File: tb/tb_lcd_screen_buffer.sv
// Directed bench for lcd_screen_buffer (COLS=16) acting as host and LCD driver.
module tb_lcd_screen_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic       wr_row;
  logic [5:0] wr_col;
  logic [7:0] wr_char;
  logic       clr;
  logic       busy;
  logic       lcd_rq;
  logic       lcd_ack;
  logic       lcd_row;
  logic [5:0] lcd_column;
  logic [7:0] lcd_character;

  int n_asserts = 0;
  int n_fail    = 0;

  always #10 clk = ~clk;

  lcd_screen_buffer #(.COLS(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .wr_char       (wr_char),
    .clr           (clr),
    .busy          (busy),
    .lcd_rq        (lcd_rq),
    .lcd_ack       (lcd_ack),
    .lcd_row       (lcd_row),
    .lcd_column    (lcd_column),
    .lcd_character (lcd_character)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic row, input logic [5:0] col, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_row  = row;
    wr_col  = col;
    wr_char = ch;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_rq(input string tag);
    int waited = 0;
    while (lcd_rq !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    check({tag, "_rq"}, 32'(lcd_rq), 32'd1);
  endtask

  // Driver model: wait for rq, check data, hold ack off, then pulse ack once.
  task automatic serve(input string tag, input int hold, input logic exp_row,
                       input logic [5:0] exp_col, input logic [7:0] exp_char);
    bit stable = 1'b1;
    wait_rq(tag);
    check({tag, "_row"}, 32'(lcd_row), 32'(exp_row));
    check({tag, "_col"}, 32'(lcd_column), 32'(exp_col));
    check({tag, "_char"}, 32'(lcd_character), 32'(exp_char));
    for (int d = 0; d < hold; d++) begin
      tick();
      if (lcd_rq !== 1'b1 || lcd_row !== exp_row || lcd_column !== exp_col ||
          lcd_character !== exp_char) stable = 1'b0;
    end
    if (hold > 1) check({tag, "_stable"}, 32'(stable), 32'd1);
    lcd_ack = 1'b1;
    tick();
    lcd_ack = 1'b0;
    check({tag, "_drop"}, 32'(lcd_rq), 32'd0);
  endtask

  task automatic blank_replay(input string tag, input int first, input int hold);
    for (int i = 0; i < 32; i++) begin
      int idx;
      idx = (first + i) % 32;
      serve($sformatf("%s%0d", tag, idx), hold, logic'(idx / 16), 6'(idx % 16), 8'h20);
    end
  endtask

  task automatic idle(input string tag, input int cycles);
    bit saw_rq   = 1'b0;
    bit saw_busy = 1'b0;
    repeat (cycles) begin
      tick();
      if (lcd_rq !== 1'b0) saw_rq = 1'b1;
      if (busy !== 1'b0) saw_busy = 1'b1;
    end
    check({tag, "_no_rq"}, 32'(saw_rq), 32'd0);
    check({tag, "_busy_low"}, 32'(saw_busy), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_row  = 1'b0;
    wr_col  = 6'd0;
    wr_char = 8'd0;
    clr     = 1'b0;
    lcd_ack = 1'b0;
    tick();
    tick();
    check("rst_rq", 32'(lcd_rq), 32'd0);
    check("rst_row", 32'(lcd_row), 32'd0);
    check("rst_col", 32'(lcd_column), 32'd0);
    check("rst_char", 32'(lcd_character), 32'h20);
    check("rst_busy", 32'(busy), 32'd1);

    // Full blank screen after reset, driver acks three cycles late.
    rst_n = 1'b1;
    blank_replay("blank", 0, 3);
    check("busy_at_last_ack", 32'(busy), 32'd1);
    idle("post_blank", 40);

    // Single write reaches the driver exactly once.
    host_write(1'b1, 6'd5, 8'h41);
    serve("w1_5", 1, 1'b1, 6'd5, 8'h41);
    idle("post_w1_5", 40);

    // Column beyond the row is dropped.
    host_write(1'b0, 6'd16, 8'h55);
    idle("col16", 40);

    // Long ack hold, then the next dirty cell rises at ack+2.
    host_write(1'b0, 6'd0, 8'h58);
    host_write(1'b0, 6'd1, 8'h59);
    serve("hold", 100, 1'b0, 6'd0, 8'h58);
    tick();
    check("rerise_rq", 32'(lcd_rq), 32'd1);
    check("rerise_col", 32'(lcd_column), 32'd1);
    serve("next", 1, 1'b0, 6'd1, 8'h59);
    idle("post_hold", 40);

    // Write to the cell in the very cycle it is latched.
    host_write(1'b0, 6'd2, 8'h43);
    host_write(1'b0, 6'd3, 8'h41);
    serve("pre", 1, 1'b0, 6'd2, 8'h43);
    host_write(1'b0, 6'd3, 8'h42);
    check("race_rq", 32'(lcd_rq), 32'd1);
    check("race_char", 32'(lcd_character), 32'h41);
    serve("race_old", 1, 1'b0, 6'd3, 8'h41);
    serve("race_new", 1, 1'b0, 6'd3, 8'h42);
    idle("post_race", 40);

    // Clear during REQ: in-flight cell completes, then all 32 blanks from ptr 17.
    host_write(1'b1, 6'd0, 8'h44);
    wait_rq("clr_pre");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_hold_rq", 32'(lcd_rq), 32'd1);
    check("clr_hold_char", 32'(lcd_character), 32'h44);
    serve("clr_inflight", 1, 1'b1, 6'd0, 8'h44);
    blank_replay("clr", 17, 1);
    idle("post_clr", 40);

    // Reset in the middle of a transaction.
    host_write(1'b0, 6'd7, 8'h46);
    wait_rq("rst_pre");
    rst_n = 1'b0;
    tick();
    check("midrst_rq", 32'(lcd_rq), 32'd0);
    check("midrst_char", 32'(lcd_character), 32'h20);
    check("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    blank_replay("rst", 0, 1);
    idle("post_rst", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_screen_buffer.md
# lcd_screen_buffer

Two-row character frame buffer that sits directly upstream of the LCD driver and owns its client rq/ack port. The host writes characters into the buffer at any rate. The block tracks which cells changed and replays only those cells to the driver, one rq/ack transaction per character, in round-robin order. This decouples the application from the slow LCD write path.

## Interface
- COLS, default 16: characters per row. Legal range 1..40.
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: reset, synchronous, active-low. One clock domain only.
- wr_en, input, 1: host write strobe, one cell per cycle.
- wr_row, input, 1: target row.
- wr_col, input, 6: target column. Ignored when ≥ COLS.
- wr_char, input, 8: character code.
- clr, input, 1: fill all cells with 8'h20 and mark them dirty.
- busy, output, 1: registered; high while any cell is dirty or a transaction is in flight.
- lcd_rq, output, 1: request to the driver.
- lcd_ack, input, 1: driver acknowledge, a single-cycle pulse.
- lcd_row, output, 1: row of the cell being sent.
- lcd_column, output, 6: column of the cell being sent.
- lcd_character, output, 8: character being sent.

## Operation
- Storage:
  - 2*COLS bytes plus one dirty bit per cell.
  - Linear index = row*COLS + col.
  - Index width = clog2(2*COLS).
- Reset (rst_n low at a clock edge):
  - All cells become 8'h20 and all dirty bits are set.
  - ptr = 0, state = SCAN.
  - lcd_rq = 0, lcd_row = 0, lcd_column = 0, lcd_character = 8'h20, busy = 1.
  - The first screen after reset is therefore a full blank.
- Host write:
  - Writes mem[idx] = wr_char and sets dirty[idx].
  - Writes with wr_col ≥ COLS have no effect.
  - clr has priority over wr_en in the same cycle.
- State SCAN:
  - Each cycle examines dirty[ptr]. ptr then increments, wrapping from 2*COLS-1 to 0.
  - If the cell is dirty: latch row, column (zero-extended) and mem[ptr] into the output registers, clear dirty[ptr], set lcd_rq = 1, go to REQ.
- State REQ:
  - Hold lcd_rq and all three data outputs stable.
  - On lcd_ack = 1: lcd_rq = 0 and go to SCAN.
- Simultaneous events:
  - Host write to the same cell in the cycle it is latched: the old character is sent and the dirty bit stays set, so the new value is resent later.
  - clr or writes during REQ do not disturb the in-flight outputs. Affected cells are re-marked dirty.
  - lcd_ack while lcd_rq = 0 is ignored.
- busy = (|dirty) | (state == REQ), registered one cycle.

## Timing
- lcd_rq rises the cycle after a dirty cell is found.
- lcd_rq falls the cycle after lcd_ack is sampled high.
- After each ack, lcd_rq is low for at least one full cycle. The earliest next rise is ack+2.
- Write-to-request latency with an idle block:
  - Best case 2 cycles: the write lands, then the cell is found at ptr.
  - Worst case 2*COLS+1 cycles.
- The driver's own power-up sequencing is invisible here. rq simply waits in REQ until ack.
- Reset mid-transaction drops lcd_rq immediately at that edge. The driver shares the same reset, so no half-transaction survives.

## Structure
- Package lcd_pkg:
  - LCD_BLANK = 8'h20.
  - Scanner state enum {SCAN, REQ}.
  - COLS_MAX = 40.
  - Column width 6.
- Natural sub-module lcd_char_mem:
  - 2*COLS x 8 storage plus dirty vector.
  - Ports: host write, clr, scanner read/clear at ptr.
  - Implements the write-wins-over-clear rule.
- Top level holds ptr, the FSM and the output registers.

## Test plan
- Reset, ack responder with 3-cycle delay: exactly 32 transactions (COLS=16), indices 0..31 in order, all characters 8'h20; busy falls after the 32nd ack.
- After idle: write row 1, col 5, 8'h41: one transaction with lcd_row=1, lcd_column=5, lcd_character=8'h41; no other rq.
- Write col 16 with COLS=16: no transaction, busy stays 0.
- Hold ack off 100 cycles during REQ: rq and data are stable for all 100 cycles; rq=0 the cycle after ack; the next rq is no earlier than ack+2.
- Write 8'h42 to (0,3) in the latch cycle of (0,3) holding 8'h41: 8'h41 is sent, then a second transaction sends 8'h42.
- clr during REQ: the in-flight character completes, then all 32 cells are resent as 8'h20. Pulse rst_n low mid-REQ: lcd_rq is 0 on the next edge and the full blank replay restarts from index 0.
